// File: rtl/quiz_game_if.sv
// Player-facing I/O bundle for quiz_game_ctrl: start/switch inputs and
// seven-segment, motor and debug outputs.
interface quiz_game_if;
  logic       start;
  logic [3:0] switch;
  logic [6:0] num_led;
  logic [6:0] point_led;
  logic [1:0] motor1;
  logic [1:0] motor2;
  logic [3:0] quiz_a;
  logic [3:0] quiz_b;
  logic [1:0] quiz_op;

  modport master (
    output start, switch,
    input  num_led, point_led, motor1, motor2, quiz_a, quiz_b, quiz_op
  );

  modport slave (
    input  start, switch,
    output num_led, point_led, motor1, motor2, quiz_a, quiz_b, quiz_op
  );
endinterface

// File: rtl/quiz_game_ctrl.sv
// Arithmetic quiz controller: LFSR question generator, one-digit show sequence,
// operator-guess judging, saturating score and motor feedback.
// Optional streak bonus (third consecutive correct answer scores +2): define QUIZ_STREAK_EN.
module quiz_game_ctrl #(
  parameter int         SHOW_CYCLES     = 150000000,
  parameter int         ANSWER_CYCLES   = 500000000,
  parameter int         FEEDBACK_CYCLES = 50000000,
  parameter int         MAX_SCORE       = 9,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  quiz_game_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GEN      = 4'd1,
    SHOW_A   = 4'd2,
    GAP_A    = 4'd3,
    SHOW_B   = 4'd4,
    GAP_B    = 4'd5,
    SHOW_RT  = 4'd6,
    GAP_RT   = 4'd7,
    SHOW_RO  = 4'd8,
    GAP_RO   = 4'd9,
    ANSWER   = 4'd10,
    FEEDBACK = 4'd11
  } state_t;

  state_t      state_r;
  logic [7:0]  lfsr_r;
  logic [31:0] cnt_r;
  logic [3:0]  sw_q_r;
  logic [3:0]  sw_prev_r;
  logic [3:0]  score_r;
  logic [3:0]  quiz_a_r;
  logic [3:0]  quiz_b_r;
  logic [1:0]  quiz_op_r;
  logic [6:0]  res_r;
  logic [6:0]  num_led_r;
  logic [6:0]  point_led_r;
  logic [1:0]  motor1_r;
  logic [1:0]  motor2_r;
`ifdef QUIZ_STREAK_EN
  logic [1:0]  streak_r;
`endif

  logic [3:0]  ra_s, rb_s, gen_a_s, gen_b_s;
  logic [1:0]  op_raw_s, gen_op_s;
  logic [6:0]  gen_r_s;
  logic [3:0]  edge_s;
  logic        one_hot_s, skip_s, guess_ok_s;
  logic [1:0]  guess_op_s;
  logic [4:0]  inc_s, sum_s;
  logic [3:0]  score_up_s, score_dn_s;
  logic [7:0]  lfsr_next_s;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] red10(input logic [3:0] x);
    logic [3:0] y;
    if (x >= 4'd10) y = x - 4'd10;
    else            y = x;
    return y;
  endfunction

  function automatic logic [6:0] apply_op(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
    logic [7:0] p;
    logic [6:0] r;
    p = {4'b0000, a} * {4'b0000, b};
    case (op)
      2'd0:    r = {3'b000, a} + {3'b000, b};
      2'd1:    r = {3'b000, a} - {3'b000, b};
      2'd2:    r = p[6:0];
      default: r = {3'b000, a} + {3'b000, b};
    endcase
    return r;
  endfunction

  // Results never exceed 81, so a compare ladder is enough for the tens digit.
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    logic [3:0] t;
    if      (v >= 7'd80) t = 4'd8;
    else if (v >= 7'd70) t = 4'd7;
    else if (v >= 7'd60) t = 4'd6;
    else if (v >= 7'd50) t = 4'd5;
    else if (v >= 7'd40) t = 4'd4;
    else if (v >= 7'd30) t = 4'd3;
    else if (v >= 7'd20) t = 4'd2;
    else if (v >= 7'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    logic [6:0] o;
    o = v - ({3'b000, tens_of(v)} * 7'd10);
    return o[3:0];
  endfunction

  // Question generation, edge detection and next-score arithmetic.
  always_comb begin
    lfsr_next_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    ra_s        = red10(lfsr_r[3:0]);
    rb_s        = red10(lfsr_r[7:4]);
    if (ra_s >= rb_s) begin
      gen_a_s = ra_s;
      gen_b_s = rb_s;
    end else begin
      gen_a_s = rb_s;
      gen_b_s = ra_s;
    end
    op_raw_s = {lfsr_r[6], lfsr_r[2]};
    gen_op_s = (op_raw_s == 2'd3) ? 2'd0 : op_raw_s;
    gen_r_s  = apply_op(gen_a_s, gen_b_s, gen_op_s);

    edge_s = sw_q_r & ~sw_prev_r;
    case (edge_s[2:0])
      3'b001:  begin one_hot_s = 1'b1; guess_op_s = 2'd0; end
      3'b010:  begin one_hot_s = 1'b1; guess_op_s = 2'd1; end
      3'b100:  begin one_hot_s = 1'b1; guess_op_s = 2'd2; end
      default: begin one_hot_s = 1'b0; guess_op_s = 2'd0; end
    endcase
    skip_s     = (edge_s == 4'b1000);
    guess_ok_s = one_hot_s && !edge_s[3] &&
                 (apply_op(quiz_a_r, quiz_b_r, guess_op_s) == res_r);

`ifdef QUIZ_STREAK_EN
    inc_s = (streak_r == 2'd2) ? 5'd2 : 5'd1;
`else
    inc_s = 5'd1;
`endif
    sum_s = {1'b0, score_r} + inc_s;
    if (sum_s > 5'(MAX_SCORE)) score_up_s = 4'(MAX_SCORE);
    else                       score_up_s = sum_s[3:0];
    score_dn_s = (score_r == 4'd0) ? 4'd0 : score_r - 4'd1;
  end

  // Game FSM with all player-visible outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      lfsr_r      <= LFSR_SEED;
      cnt_r       <= 32'd0;
      sw_q_r      <= 4'd0;
      sw_prev_r   <= 4'd0;
      score_r     <= 4'd0;
      quiz_a_r    <= 4'd0;
      quiz_b_r    <= 4'd0;
      quiz_op_r   <= 2'd0;
      res_r       <= 7'd0;
      num_led_r   <= 7'd0;
      point_led_r <= 7'b1111110;
      motor1_r    <= 2'b00;
      motor2_r    <= 2'b00;
`ifdef QUIZ_STREAK_EN
      streak_r    <= 2'd0;
`endif
    end else begin
      lfsr_r    <= lfsr_next_s;
      sw_q_r    <= bus.switch;
      sw_prev_r <= sw_q_r;
      case (state_r)
        IDLE: begin
          num_led_r <= 7'd0;
          if (bus.start) state_r <= GEN;
          else           state_r <= IDLE;
        end
        GEN: begin
          quiz_a_r  <= gen_a_s;
          quiz_b_r  <= gen_b_s;
          quiz_op_r <= gen_op_s;
          res_r     <= gen_r_s;
          num_led_r <= seg7(gen_a_s);
          cnt_r     <= 32'(SHOW_CYCLES);
          state_r   <= SHOW_A;
        end
        SHOW_A, SHOW_B, SHOW_RT, SHOW_RO: begin
          if (cnt_r == 32'd1) begin
            num_led_r <= 7'd0;
            state_r   <= state_t'(state_r + 4'd1);
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end
        GAP_A: begin
          num_led_r <= seg7(quiz_b_r);
          cnt_r     <= 32'(SHOW_CYCLES);
          state_r   <= SHOW_B;
        end
        GAP_B: begin
          num_led_r <= (res_r < 7'd10) ? 7'd0 : seg7(tens_of(res_r));
          cnt_r     <= 32'(SHOW_CYCLES);
          state_r   <= SHOW_RT;
        end
        GAP_RT: begin
          num_led_r <= seg7(ones_of(res_r));
          cnt_r     <= 32'(SHOW_CYCLES);
          state_r   <= SHOW_RO;
        end
        GAP_RO: begin
          num_led_r <= 7'd0;
          cnt_r     <= 32'(ANSWER_CYCLES);
          state_r   <= ANSWER;
        end
        ANSWER: begin
          if (skip_s) begin
            state_r <= GEN;
          end else if (guess_ok_s) begin
            score_r     <= score_up_s;
            point_led_r <= seg7(score_up_s);
            motor1_r    <= 2'b10;
            cnt_r       <= 32'(FEEDBACK_CYCLES);
            state_r     <= FEEDBACK;
`ifdef QUIZ_STREAK_EN
            streak_r    <= (streak_r == 2'd2) ? 2'd0 : streak_r + 2'd1;
`endif
          end else if ((edge_s != 4'b0000) || (cnt_r == 32'd1)) begin
            score_r     <= score_dn_s;
            point_led_r <= seg7(score_dn_s);
            motor2_r    <= 2'b10;
            cnt_r       <= 32'(FEEDBACK_CYCLES);
            state_r     <= FEEDBACK;
`ifdef QUIZ_STREAK_EN
            streak_r    <= 2'd0;
`endif
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end
        FEEDBACK: begin
          if (cnt_r == 32'd1) begin
            motor1_r <= 2'b00;
            motor2_r <= 2'b00;
            state_r  <= GEN;
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end
        default: begin
          num_led_r <= 7'd0;
          motor1_r  <= 2'b00;
          motor2_r  <= 2'b00;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.num_led   = num_led_r;
  assign bus.point_led = point_led_r;
  assign bus.motor1    = motor1_r;
  assign bus.motor2    = motor2_r;
  assign bus.quiz_a    = quiz_a_r;
  assign bus.quiz_b    = quiz_b_r;
  assign bus.quiz_op   = quiz_op_r;

endmodule

// File: tb/tb_quiz_game_ctrl.sv
// Directed bench for quiz_game_ctrl with short show/answer/feedback windows;
// expected question values come from an independent LFSR reference.
module tb_quiz_game_ctrl;
  localparam int SHOW = 4;
  localparam int ANS  = 20;
  localparam int FB   = 3;

  localparam int M_OK     = 0;
  localparam int M_BAD2   = 1;
  localparam int M_BADOP  = 2;
  localparam int M_SKIP   = 3;
  localparam int M_TMO    = 4;
  localparam int M_SKIPOP = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  quiz_game_if bus();

  quiz_game_ctrl #(
    .SHOW_CYCLES(SHOW), .ANSWER_CYCLES(ANS), .FEEDBACK_CYCLES(FB),
    .MAX_SCORE(9), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mlfsr;
  int run_exp[10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int calc(input int a, input int b, input int op);
    if (op == 0) return a + b;
    else if (op == 1) return a - b;
    else return a * b;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) mlfsr = lfsr_step(mlfsr);
    #1;
  endtask

  // Called during the GEN cycle; returns once the DUT is back in GEN.
  task automatic play(input int mode, input int exp_score, input int exp_motor, input bit keep);
    int ra, rb, a, b, op, r, alt;
    logic [6:0] dig[4];
    logic [3:0] pat;
    logic [7:0] l;
    l  = mlfsr;
    ra = int'(l[3:0]); if (ra >= 10) ra -= 10;
    rb = int'(l[7:4]); if (rb >= 10) rb -= 10;
    a  = (ra >= rb) ? ra : rb;
    b  = (ra >= rb) ? rb : ra;
    op = int'({l[6], l[2]}); if (op == 3) op = 0;
    r  = calc(a, b, op);
    tick();
    chk("quiz_a", 32'(bus.quiz_a), 32'(a));
    chk("quiz_b", 32'(bus.quiz_b), 32'(b));
    chk("quiz_op", 32'(bus.quiz_op), 32'(op));
    dig[0] = seg(a);
    dig[1] = seg(b);
    dig[2] = (r < 10) ? 7'd0 : seg(r / 10);
    dig[3] = seg(r % 10);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SHOW; c++) begin
        chk("show_digit", 32'(bus.num_led), 32'(dig[d]));
        tick();
      end
      chk("show_gap", 32'(bus.num_led), 32'd0);
      tick();
    end
    chk("answer_blank", 32'(bus.num_led), 32'd0);
    chk("motor_idle", 32'({bus.motor1, bus.motor2}), 32'd0);
    case (mode)
      M_OK:     pat = 4'b0001 << op;
      M_BAD2:   pat = 4'b0011;
      M_SKIP:   pat = 4'b1000;
      M_SKIPOP: pat = 4'b1001;
      M_BADOP: begin
        pat = 4'b0011;
        for (int k = 2; k >= 0; k--) if (calc(a, b, k) != r) pat = 4'b0001 << k;
      end
      default:  pat = 4'b0000;
    endcase
    if (mode == M_TMO) begin
      for (int i = 0; i < ANS - 1; i++) tick();
      chk("motor_before_expiry", 32'({bus.motor1, bus.motor2}), 32'd0);
      tick();
    end else begin
      bus.switch = pat;
      tick();
      tick();
    end
    chk("score", 32'(bus.point_led), 32'(seg(exp_score)));
    if (!keep) bus.switch = 4'b0000;
    if (exp_motor == 0) begin
      chk("no_motor", 32'({bus.motor1, bus.motor2}), 32'd0);
    end else begin
      for (int c = 0; c < FB; c++) begin
        chk("motor_on", 32'({bus.motor1, bus.motor2}), (exp_motor == 1) ? 32'h8 : 32'h2);
        tick();
      end
      chk("motor_off", 32'({bus.motor1, bus.motor2}), 32'd0);
    end
  endtask

  initial begin
    int s3;
    bus.start  = 1'b0;
    bus.switch = 4'b0000;
    mlfsr      = 8'hA5;
`ifdef QUIZ_STREAK_EN
    s3      = 4;
    run_exp = '{1, 2, 4, 5, 6, 8, 9, 9, 9, 9};
`else
    s3      = 3;
    run_exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9};
`endif
    tick();
    tick();
    reset = 1'b0;
    chk("rst_num_led", 32'(bus.num_led), 32'd0);
    chk("rst_point_led", 32'(bus.point_led), 32'h7E);

    // Reset in the middle of SHOW_B.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < SHOW + 3; i++) tick();
    chk("pre_reset_shown", 32'(bus.num_led != 7'd0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_num_led", 32'(bus.num_led), 32'd0);
    chk("rst_mid_point", 32'(bus.point_led), 32'h7E);
    chk("rst_mid_motor", 32'({bus.motor1, bus.motor2}), 32'd0);
    chk("rst_mid_quiz", 32'({bus.quiz_a, bus.quiz_b, bus.quiz_op}), 32'd0);
    mlfsr = 8'hA5;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_hold", 32'({bus.num_led, bus.quiz_a}), 32'd0);
    end

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    play(M_OK,     1,      1, 1'b0);
    play(M_OK,     2,      1, 1'b0);
    play(M_OK,     s3,     1, 1'b0);
    play(M_BAD2,   s3 - 1, 2, 1'b0);
    play(M_TMO,    s3 - 2, 2, 1'b0);
    play(M_SKIP,   s3 - 2, 0, 1'b1);
    play(M_TMO,    s3 - 3, 2, 1'b0);
    play(M_BAD2,   0,      2, 1'b0);
    play(M_SKIPOP, 0,      2, 1'b0);
    play(M_BADOP,  0,      2, 1'b0);
    for (int i = 0; i < 10; i++) play(M_OK, run_exp[i], 1, 1'b0);
    play(M_SKIP,   9,      0, 1'b0);
    play(M_BAD2,   8,      2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
